// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder. A request accepted on a rising clk edge captures both
// operands and the carry-in, then one full-adder bit is evaluated per clock,
// LSB first, for WIDTH clocks. The finished sum and carry-out are loaded into
// output registers and flagged by a one-cycle done pulse.
//
// Parameters
//   WIDTH  operand/result width in bits (2..32), default 8
//
// Ports
//   clk    in   single clock, all state changes on the rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request to begin an addition (accepted in IDLE or DONE)
//   a      in   operand A, captured on the accepting edge
//   b      in   operand B, captured on the accepting edge
//   cin    in   carry-in, captured on the accepting edge
//   busy   out  high while the bit-serial addition is in progress
//   done   out  one-cycle pulse, sum/cout valid from this cycle on
//   sum    out  registered a+b+cin modulo 2^WIDTH, held until next result
//   cout   out  registered carry-out of the full addition
// ---------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // The counter only has to reach WIDTH-1; the last shift is detected by
  // comparing against that value rather than counting up to WIDTH.
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] op_a_q,   op_a_d;
  logic [WIDTH-1:0] op_b_q,   op_b_d;
  logic             carry_q,  carry_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] psum_q,   psum_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic             cout_q,   cout_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic             bit_sum;
  logic             bit_carry;
  logic [WIDTH-1:0] psum_shifted;

  // One full-adder slice working on the current operand LSBs.
  always_comb begin
    bit_sum      = op_a_q[0] ^ op_b_q[0] ^ carry_q;
    bit_carry    = (op_a_q[0] & op_b_q[0]) |
                   (op_a_q[0] & carry_q)   |
                   (op_b_q[0] & carry_q);
    // New bits enter at the MSB, so after WIDTH shifts bit 0 of the
    // result has walked down to the LSB position.
    psum_shifted = {bit_sum, psum_q[WIDTH-1:1]};
  end

  // Next-state logic. DONE behaves like IDLE with respect to start so that
  // a held or re-asserted start chains additions with no idle gap.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          op_a_d  = a;
          op_b_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          psum_d  = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        op_a_d  = {1'b0, op_a_q[WIDTH-1:1]};
        op_b_d  = {1'b0, op_b_q[WIDTH-1:1]};
        carry_d = bit_carry;
        psum_d  = psum_shifted;
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          sum_d   = psum_shifted;
          cout_d  = bit_carry;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered copies of the next state so they line
    // up exactly with the cycles spent in SHIFT and DONE.
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder. An 8-bit instance is driven with a
// table of directed vectors, hand-written multi-cycle sequences (start during
// SHIFT, back-to-back start, reset mid-SHIFT) and random operands checked
// against a plain arithmetic model. A 4-bit instance is checked over every
// (a, b, cin) combination.
// ---------------------------------------------------------------------------
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       cin4;
  logic       busy4;
  logic       done4;
  logic [3:0] sum4;
  logic       cout4;

  int         n_checks = 0;
  int         n_fail   = 0;

  // Result the 8-bit instance should currently be presenting on sum/cout.
  logic [7:0] held_sum;
  logic       held_cout;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Runs one 8-bit addition and checks every cycle of it.
  //   inject_k  : -1 none, 0 keep start high throughout, 1..7 pulse start
  //               (with a=0x11) during that SHIFT cycle
  //   pre_driven: start/operands were already set up by the previous call
  //   chain     : leave start high with the next operands at the done cycle
  task automatic applyStimulus(input logic [7:0] op_a, input logic [7:0] op_b,
                               input logic op_cin,
                               input logic [7:0] exp_sum, input logic exp_cout,
                               input int inject_k, input bit pre_driven,
                               input bit chain, input logic [7:0] nxt_a,
                               input logic [7:0] nxt_b, input logic nxt_cin);
    if (!pre_driven) begin
      @(negedge clk);
      start = 1'b1;
      a     = op_a;
      b     = op_b;
      cin   = op_cin;
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      // Operands are scrambled after acceptance; the result must not care.
      start = (inject_k == 0) || (k == inject_k);
      a     = (k == inject_k) ? 8'h11 : 8'($urandom);
      b     = 8'($urandom);
      cin   = 1'($urandom);
      checkOutput("busy_during_shift", {31'd0, busy}, 32'd1);
      checkOutput("done_during_shift", {31'd0, done}, 32'd0);
      checkOutput("sum_held_in_shift", {24'd0, sum}, {24'd0, held_sum});
      checkOutput("cout_held_in_shift", {31'd0, cout}, {31'd0, held_cout});
    end
    @(negedge clk);
    checkOutput("done_pulse", {31'd0, done}, 32'd1);
    checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
    checkOutput("sum_result", {24'd0, sum}, {24'd0, exp_sum});
    checkOutput("cout_result", {31'd0, cout}, {31'd0, exp_cout});
    held_sum  = exp_sum;
    held_cout = exp_cout;
    if (chain) begin
      start = 1'b1;
      a     = nxt_a;
      b     = nxt_b;
      cin   = nxt_cin;
    end else begin
      start = 1'b0;
      @(negedge clk);
      checkOutput("done_single_pulse", {31'd0, done}, 32'd0);
      checkOutput("busy_idle", {31'd0, busy}, 32'd0);
      checkOutput("sum_held_idle", {24'd0, sum}, {24'd0, held_sum});
    end
  endtask

  initial begin
    logic [8:0] model;
    logic [4:0] model4;
    int         lat;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    int         inj;

    vecs[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[6] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b0};

    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;
    start4 = 1'b0;
    a4     = '0;
    b4     = '0;
    cin4   = 1'b0;
    held_sum  = '0;
    held_cout = 1'b0;

    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_sum", {24'd0, sum}, 32'd0);
    checkOutput("reset_cout", {31'd0, cout}, 32'd0);
    checkOutput("reset_w4", {26'd0, busy4, done4, cout4, sum4[2:0]}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum,
                    vecs[i].exp_cout, -1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    end

    // Start pulsed on SHIFT cycle 3 must be ignored.
    applyStimulus(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 3, 1'b0, 1'b0,
                  8'h00, 8'h00, 1'b0);

    // Start held through DONE chains a second addition with no idle gap;
    // the first result stays visible during the second SHIFT.
    applyStimulus(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 0, 1'b0, 1'b1,
                  8'h80, 8'h80, 1'b0);
    applyStimulus(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0,
                  8'h00, 8'h00, 1'b0);

    // Give the outputs a nonzero value so the reset clear is observable.
    applyStimulus(8'h21, 8'h43, 1'b1, 8'h65, 1'b0, -1, 1'b0, 1'b0,
                  8'h00, 8'h00, 1'b0);

    // Reset on SHIFT cycle 4: outputs clear without a clock edge.
    @(negedge clk);
    start = 1'b1;
    a     = 8'h55;
    b     = 8'h66;
    cin   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("busy_before_reset", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("async_reset_sum", {24'd0, sum}, 32'd0);
    checkOutput("async_reset_cout", {31'd0, cout}, 32'd0);
    checkOutput("async_reset_done", {31'd0, done}, 32'd0);
    // Start while reset is held must be ignored.
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("start_in_reset_busy", {31'd0, busy}, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    held_sum  = 8'h00;
    held_cout = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("no_done_after_reset", {30'd0, busy, done}, 32'd0);
    end
    applyStimulus(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, -1, 1'b0, 1'b0,
                  8'h00, 8'h00, 1'b0);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      ra    = 8'($urandom);
      rb    = 8'($urandom);
      rc    = 1'($urandom);
      inj   = (i % 3 == 0) ? int'($urandom_range(7, 1)) : -1;
      model = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      applyStimulus(ra, rb, rc, model[7:0], model[8], inj, 1'b0, 1'b0,
                    8'h00, 8'h00, 1'b0);
    end

    // 4-bit instance, every operand combination; done is expected on the
    // fifth sampled cycle after driving start (accept edge plus 4 shifts).
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          @(negedge clk);
          start4 = 1'b1;
          a4     = 4'(ai);
          b4     = 4'(bi);
          cin4   = 1'(ci);
          @(negedge clk);
          start4 = 1'b0;
          a4     = 4'($urandom);
          b4     = 4'($urandom);
          lat    = 1;
          while (!done4 && lat < 12) begin
            @(negedge clk);
            lat++;
          end
          model4 = 5'(ai + bi + ci);
          checkOutput("w4_latency_result", {23'd0, lat[3:0], cout4, sum4},
                      {23'd0, 4'd5, model4});
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide port start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 SHALL provide port a  input  WIDTH  operand A, captured when start is accepted.
REQ-006 SHALL provide port b  input  WIDTH  operand B, captured when start is accepted.
REQ-007 SHALL provide port cin  input  1  carry-in, captured when start is accepted.
REQ-008 SHALL provide port busy  output  1  high while an addition is in progress.
REQ-009 SHALL provide port done  output  1  one-cycle pulse marking sum/cout valid.
REQ-010 SHALL provide port sum  output  WIDTH  registered result a+b+cin modulo 2^WIDTH.
REQ-011 SHALL provide port cout  output  1  registered carry-out of the full addition.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE; all outputs registered.
REQ-013 IDLE: start=1 at an edge SHALL accept the request: capture a, b, cin into internal operand shift registers and carry flop, clear bit counter and partial-sum register, go to SHIFT.
REQ-014 SHIFT: each edge SHALL add the operand LSBs plus the carry flop as one full-adder bit (sum bit = a0^b0^c, carry = majority), shift the sum bit into the partial-sum MSB, shift both operands right by one, update the carry flop, increment the counter.
REQ-015 SHIFT SHALL last exactly WIDTH edges; on the WIDTH-th shift edge the FSM SHALL go to DONE and load sum/cout from the final partial sum and carry.
REQ-016 done SHALL be high for exactly the one cycle the FSM is in DONE, i.e. asserted WIDTH edges after the start-accepting edge.
REQ-017 busy SHALL be high exactly while the FSM is in SHIFT (WIDTH cycles).
REQ-018 start while in SHIFT SHALL be ignored; operands and progress unaffected.
REQ-019 start=1 while in DONE SHALL be accepted as in REQ-013 (back-to-back, no IDLE cycle); otherwise DONE returns to IDLE.
REQ-020 sum and cout SHALL hold the last completed result, unchanged during a subsequent SHIFT, until the next DONE load.
REQ-021 a, b, cin changes after the accepting edge SHALL NOT affect the in-progress result.
REQ-022 Result SHALL equal {cout,sum} = a + b + cin for all operand values, including all-ones overflow.

Reset
REQ-023 rst_n=0 SHALL immediately, independent of clk, force FSM to IDLE, counter/operand/partial registers to 0, carry flop 0, busy=0, done=0, sum=0, cout=0.
REQ-024 Reset mid-SHIFT SHALL discard the partial result; no done pulse SHALL follow; first start after rst_n rises SHALL be processed normally.
REQ-025 While rst_n=0 start SHALL be ignored.

Verification (WIDTH=8)
REQ-026 a=0x3C, b=0x0F, cin=0, start pulsed -> busy high 8 cycles, done pulse on 8th edge after start, sum=0x4B, cout=0.
REQ-027 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
REQ-028 start re-pulsed with a=0x11 on cycle 3 of SHIFT of a=0x01,b=0x01 -> ignored, result sum=0x02, cout=0, single done pulse.
REQ-029 start held high through DONE with a=0x80,b=0x80,cin=0 -> second addition begins with no IDLE cycle, sum=0x00, cout=1; prior result held until second done.
REQ-030 rst_n pulsed low on cycle 4 of SHIFT -> all outputs 0 asynchronously, no done; next addition 0x12+0x34 -> sum=0x46, cout=0.
REQ-031 WIDTH=4 exhaustive: all 512 (a,b,cin) combinations checked against a+b+cin reference model.
